// File: rtl/rot_pkg.sv
// Shared widths, direction/state encodings and the ROR-to-ROL amount mapping
// for the shared rotate scheduler.
package rot_pkg;

    localparam int ROT_W = 32;
    localparam int AMT_W = 5;

    typedef enum logic {
        ROT_LEFT  = 1'b0,
        ROT_RIGHT = 1'b1
    } rot_dir_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } rot_state_e;

    // A right rotate by n equals a left rotate by (32 - n) mod 32.
    function automatic logic [AMT_W-1:0] eff_amt(input rot_dir_e dir, input logic [AMT_W-1:0] amt);
        return (dir == ROT_RIGHT) ? (~amt + 1'b1) : amt;
    endfunction

endpackage

// File: rtl/rot_core.sv
// Combinational 32-bit rotate-left by a 5-bit amount.
// Zero latency, no flow control.
module rot_core
    import rot_pkg::*;
(
    input  logic [ROT_W-1:0] din,
    input  logic [AMT_W-1:0] amt,
    output logic [ROT_W-1:0] dout
);

    // amt == 0 makes the right shift 32 wide, which yields zero and leaves din intact.
    assign dout = (din << amt) | (din >> (ROT_W - int'(amt)));

endmodule

// File: rtl/rot_share_ctrl.sv
// Round-robin shared rotate unit: accept in IDLE, result registered 2 cycles later.
// Response is held stable and no request is accepted until rsp_ready.
module rot_share_ctrl
    import rot_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*ROT_W-1:0] req_data,
    input  logic [NUM_REQ*AMT_W-1:0] req_amt,
    input  logic [NUM_REQ-1:0]       req_dir,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ROT_W-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy
);

    rot_state_e       state_q, state_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [ROT_W-1:0] op_q, op_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic [ROT_W-1:0] rsp_data_q, rsp_data_d;
    logic [ROT_W-1:0] rot_out;
    logic             grant_vld;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  cand;

    // Search starts one past the last winner so the previous grantee is checked last.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_d         = op_q;
        amt_d        = amt_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    req_ready[grant_idx] = 1'b1;
                    op_d         = req_data[grant_idx*ROT_W +: ROT_W];
                    amt_d        = eff_amt(rot_dir_e'(req_dir[grant_idx]),
                                           req_amt[grant_idx*AMT_W +: AMT_W]);
                    id_d         = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d = rot_out;
                rsp_id_d   = id_q;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            op_q         <= '0;
            amt_q        <= '0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_q         <= op_d;
            amt_q        <= amt_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    rot_core u_rot_core (
        .din  (op_q),
        .amt  (amt_q),
        .dout (rot_out)
    );

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_rot_share_ctrl.sv
// Directed bench for rot_share_ctrl: vector table plus fairness, backpressure and reset sequences.
module tb_rot_share_ctrl;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_data = '0;
    logic [NUM_REQ*5-1:0]  req_amt = '0;
    logic [NUM_REQ-1:0]    req_dir = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [31:0]           rsp_data;
    logic [ID_W-1:0]       rsp_id;
    logic                  busy;

    int errors = 0;
    int checks = 0;

    rot_share_ctrl #(.NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_dir   (req_dir),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        dir;
        logic [4:0]  amt;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drive(input int idx, input logic dir, input logic [4:0] amt, input logic [31:0] d);
        req_data[idx*32 +: 32] = d;
        req_amt[idx*5 +: 5]    = amt;
        req_dir[idx]           = dir;
        req_valid[idx]         = 1'b1;
    endtask

    // Single request from IDLE, full cycle-by-cycle check of the 2-cycle latency.
    task automatic do_op(input int n, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", n);
        drive(v.idx, v.dir, v.amt, v.d);
        rsp_ready = 1'b0;
        #1;
        chk({tag, "_req_ready"}, 32'(req_ready), 32'(1 << v.idx));
        step();
        req_valid = '0;
        chk({tag, "_t1_busy"}, 32'(busy), 32'd1);
        chk({tag, "_t1_rsp_valid"}, 32'(rsp_valid), 32'd0);
        step();
        chk({tag, "_t2_rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_rsp_data"}, rsp_data, v.exp);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(v.idx));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, "_t3_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int grant_cyc[$];
        int grant_id[$];
        logic seen_rsp;

        vecs[0] = '{0, 1'b0, 5'd1,  32'h8000_0001, 32'h0000_0003};
        vecs[1] = '{1, 1'b1, 5'd4,  32'h0000_0001, 32'h1000_0000};
        vecs[2] = '{0, 1'b1, 5'd0,  32'h1234_5678, 32'h1234_5678};
        vecs[3] = '{1, 1'b0, 5'd31, 32'hA5A5_A5A5, 32'hD2D2_D2D2};
        vecs[4] = '{0, 1'b1, 5'd31, 32'hA5A5_A5A5, 32'h4B4B_4B4B};
        vecs[5] = '{1, 1'b0, 5'd4,  32'hF000_0000, 32'h0000_000F};
        vecs[6] = '{0, 1'b0, 5'd8,  32'h1234_5678, 32'h3456_7812};
        vecs[7] = '{1, 1'b1, 5'd8,  32'h1234_5678, 32'h7812_3456};
        vecs[8] = '{0, 1'b0, 5'd0,  32'h1234_5678, 32'h1234_5678};

        // Reset state
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        do_reset();

        for (int i = 0; i < 9; i++) begin
            do_op(i, vecs[i]);
        end

        // Fairness: both valid from reset, consumer always ready
        do_reset();
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req_ready != '0) begin
                grant_cyc.push_back(c);
                grant_id.push_back(req_ready[1] ? 1 : 0);
                chk("fair_onehot", 32'($countones(req_ready)), 32'd1);
                chk("fair_grant_in_idle", 32'(busy), 32'd0);
            end
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        chk("fair_grant_count", 32'(grant_id.size()), 32'd4);
        for (int g = 0; g < 4 && g < grant_id.size(); g++) begin
            chk($sformatf("fair_order%0d", g), 32'(grant_id[g]), 32'(g % 2));
            if (g > 0)
                chk($sformatf("fair_spacing%0d", g), 32'(grant_cyc[g] - grant_cyc[g-1]), 32'd3);
        end
        step();
        step();

        // Backpressure: response held 5 cycles while req0 keeps asking
        do_reset();
        drive(0, 1'b0, 5'd4, 32'hF000_0000);
        step();
        step();
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", rsp_data, 32'h0000_000F);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            if (c < 4) step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        req_valid = '0;
        #1;
        chk("bp_idle_after", 32'(busy), 32'd0);
        req_valid[0] = 1'b1;
        #1;
        chk("bp_regrant", 32'(req_ready), 32'd1);
        req_valid = '0;
        step();
        step();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Reset during EXEC discards the operation; requester 0 wins afterwards
        drive(0, 1'b0, 5'd1, 32'h0000_0001);
        step();
        req_valid = '0;
        chk("mr_exec_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;
        seen_rsp = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid || busy) seen_rsp = 1'b1;
            step();
        end
        chk("mr_no_response", 32'(seen_rsp), 32'd0);
        req_valid = 2'b11;
        #1;
        chk("mr_first_grant", 32'(req_ready), 32'd1);
        req_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rot_share_ctrl.md
# rot_share_ctrl

Round-robin scheduler that shares one 32-bit rotate datapath among `NUM_REQ` requesters in the single-cycle core's execute cluster. Each requester supplies an operand, a 5-bit amount and a direction (left or right) over a valid/ready handshake. The block rotates the operand using a left-rotate core, with right rotates mapped onto left rotates. It returns the registered result, tagged with the requester index, over a valid/ready response channel.

## Interface
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `ID_W`, default `$clog2(NUM_REQ)` (minimum 1): width of the response tag.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request strobe.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit is high in any cycle.
- `req_data`  in  NUM_REQ*32  operand; requester i occupies bits [32i+31:32i].
- `req_amt`  in  NUM_REQ*5  rotate amount; requester i occupies bits [5i+4:5i].
- `req_dir`  in  NUM_REQ  0 = rotate left, 1 = rotate right.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_data`  out  32  rotated result.
- `rsp_id`  out  ID_W  index of the requester that was served.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE**
  - Arbiter picks the first requester with `req_valid` set, searching from `last_grant+1` and wrapping modulo `NUM_REQ`.
  - `req_ready[grant]` = 1; all other `req_ready` bits are 0.
  - On handshake: capture the operand, the effective amount and the id; update `last_grant` to the granted index; go to EXEC.
  - With no valid request, stay in IDLE and drive `req_ready` = 0.
- **EXEC**
  - Feed the captured operand and effective amount to `rot_core`.
  - Register the result into `rsp_data` and the captured id into `rsp_id`.
  - Go to RESP.
- **RESP**
  - `rsp_valid` = 1.
  - On `rsp_ready` = 1, go to IDLE.
  - Otherwise hold: `rsp_data` and `rsp_id` stay stable.
- **Effective amount:** ROL uses `amt`; ROR uses `(32 - amt) mod 32`, i.e. the 5-bit two's complement of `amt`. An amount of 0 returns the operand unchanged in both directions.
- **Arbitration:**
  - `req_ready` is a combinational function of `req_valid` and `last_grant`, and is asserted only in IDLE.
  - Requesters must hold their request fields stable while `req_valid` is high and unaccepted.
- **Fairness:** with all requesters continuously valid, grants rotate strictly 0, 1, …, NUM_REQ-1, 0, …
- **Reset values:**
  - state = IDLE, and `last_grant` = NUM_REQ-1, so requester 0 wins first.
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0.
  - `req_ready` = 0, `busy` = 0.
- **Reset mid-operation:** asserting `rst` in EXEC or RESP immediately drops `rsp_valid` and `busy` and discards the in-flight operation. No response is ever issued for it.

## Timing
- Request handshake in cycle T.
- T+1: state is EXEC and `busy` = 1.
- T+2: `rsp_valid` = 1 with the final `rsp_data` and `rsp_id`. Latency is 2 cycles from accept to result.
- If `rsp_ready` = 1 at T+2, state returns to IDLE at T+3 and the next accept can occur in T+3. Peak throughput is one operation per 3 cycles.
- Backpressure: while `rsp_valid` && !`rsp_ready`, all outputs are frozen and all `req_ready` bits are 0.
- `rsp_valid` never drops without a handshake, except on reset.
- A request arriving during EXEC or RESP waits. Its priority is evaluated in the first IDLE cycle against the updated `last_grant`.

## Structure
- Package `rot_pkg`:
  - `ROT_W` = 32 and `AMT_W` = 5.
  - Enum `rot_dir_e` {ROT_LEFT, ROT_RIGHT}.
  - Enum `rot_state_e` {IDLE, EXEC, RESP}.
- Sub-module `rot_core`: a combinational 32-bit rotate-left by a 5-bit amount, instantiated once in the EXEC path.
- The arbiter, FSM and output registers live in `rot_share_ctrl`.

## Test plan
- **Basic ROL:** after reset, req0 ROL `0x80000001` amt 1 -> `rsp_data` = `0x00000003`, `rsp_id` = 0, `rsp_valid` rises exactly 2 cycles after the handshake.
- **ROR mapping:** req1 ROR `0x00000001` amt 4 -> `0x10000000`, id 1. ROR `0x12345678` amt 0 -> `0x12345678`.
- **Fairness:** req0 and req1 held valid from reset, `rsp_ready` tied high -> grants in order 0, 1, 0, 1. Each operation completes in 3 cycles; no grant occurs outside IDLE.
- **Backpressure:** ROL `0xF0000000` amt 4, `rsp_ready` held low for 5 cycles -> `rsp_data` stays `0x0000000F`, `req_ready` stays 0 while req0 is valid. Handshake occurs in the cycle `rsp_ready` rises; state is IDLE the next cycle.
- **Wrap-around:** ROL `0xA5A5A5A5` amt 31 -> `0xD2D2D2D2`. ROR amt 31 of the same value -> `0x4B4B4B4B`.
- **Reset mid-operation:** assert `rst` during EXEC -> `rsp_valid` and `busy` are 0 immediately and no response appears afterward. The first post-reset grant goes to requester 0.
